// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction fetch unit and the control decoder.
package ifu_pkg;

  localparam int XLEN_DEF = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [31:0]         instr;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush and occupancy count; head entry is read combinationally.
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_pop;

  assign empty    = (count_reg == '0);
  assign do_pop   = pop && !empty;
  assign count    = count_reg;
  assign pop_data = mem[rd_ptr_reg];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)   wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential PC generation, in-order response buffering, redirect flush.
// Optional macro IFU_MISALIGN_CHECK_EN adds the sticky fetch_misaligned output.
module instr_fetch
  import ifu_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [6:0]      if_opcode,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
`ifdef IFU_MISALIGN_CHECK_EN
  , output logic          fetch_misaligned
`endif
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next, target_pc, resp_pc_reg;
  logic [CW-1:0]   outstanding_reg, outstanding_next, drop_reg, drop_next, occupancy;
  logic [CW:0]     budget;
  logic            run_reg, halt, grant, discard, push, pop, empty, rsp_dec;
  logic [XLEN+31:0] head;

`ifdef IFU_MISALIGN_CHECK_EN
  logic misaligned_reg;
  assign target_pc        = redirect_pc;
  assign halt             = misaligned_reg;
  assign fetch_misaligned = misaligned_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           misaligned_reg <= 1'b0;
    else if (redirect) misaligned_reg <= |redirect_pc[1:0];
  end
`else
  logic unused_pc_lo;
  assign target_pc    = {redirect_pc[XLEN-1:2], 2'b00};
  assign halt         = 1'b0;
  assign unused_pc_lo = ^redirect_pc[1:0];
`endif

  // An entry leaving the buffer this cycle frees its slot for a new request,
  // which is what lets a 2-deep buffer sustain one instruction per cycle.
  assign pop      = if_valid && if_ready;
  assign budget   = {1'b0, outstanding_reg} + {1'b0, occupancy} - {{CW{1'b0}}, pop};
  assign imem_req = run_reg && !halt && (budget < (CW+1)'(BUF_DEPTH));
  assign imem_addr = fetch_pc_reg;
  assign grant    = imem_req && imem_gnt;

  assign rsp_dec  = imem_rvalid && (outstanding_reg != '0);
  assign discard  = imem_rvalid && (drop_reg != '0);
  assign push     = imem_rvalid && !discard && !redirect && !halt;

  assign outstanding_next = outstanding_reg + CW'(grant) - CW'(rsp_dec);
  assign drop_next        = redirect ? outstanding_next : (drop_reg - CW'(discard));
  assign fetch_pc_next    = redirect ? target_pc
                          : grant    ? fetch_pc_reg + XLEN'(4)
                          : fetch_pc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_reg         <= 1'b0;
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_reg        <= '0;
    end else begin
      run_reg         <= 1'b1;
      fetch_pc_reg    <= fetch_pc_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      // Tracks the PC of the next kept response; responses return in order.
      if (redirect)  resp_pc_reg <= target_pc;
      else if (push) resp_pc_reg <= resp_pc_reg + XLEN'(4);
    end
  end

  ifu_fifo #(
    .WIDTH (XLEN + 32),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data ({resp_pc_reg, imem_rdata}),
    .pop       (pop),
    .pop_data  (head),
    .count     (occupancy),
    .empty     (empty)
  );

  assign if_valid  = !empty;
  assign if_pc     = empty ? RESET_PC : head[XLEN+31:32];
  assign if_instr  = empty ? NOP : head[31:0];
  assign if_opcode = if_instr[6:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model plus next-PC stream model, with directed scenarios.
module tb_instr_fetch;
  import ifu_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk, rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, if_ready, redirect;
  logic [31:0] if_instr, if_pc, redirect_pc;
  logic [6:0]  if_opcode;
`ifdef IFU_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  instr_fetch #(.XLEN(32), .RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_opcode   (if_opcode),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef IFU_MISALIGN_CHECK_EN
    , .fetch_misaligned (fetch_misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat = 1;
  logic        gnt_rand = 1'b0;
  rsp_t        mq[$];
  logic [31:0] dlog[$];
  int          dcyc[$];
  logic [31:0] exp_pc;

  // Instruction word derived from its address so every fetch is traceable.
  function automatic logic [31:0] mdata(input logic [31:0] a);
    logic [6:0] op;
    case (a[3:2])
      2'd0:    op = OP_RTYPE;
      2'd1:    op = OP_LOAD;
      2'd2:    op = OP_STORE;
      default: op = OP_BRANCH;
    endcase
    return {a[26:2], op};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_dlog(input int n, input int budget);
    int k = 0;
    while (dlog.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (dlog.size() < n) chk("wait_timeout", 64'(dlog.size()), 64'(n));
  endtask

  // Memory model and per-cycle checker against the in-order next-PC stream.
  initial begin : mon
    logic        prev_hold, prev_wait;
    logic [31:0] prev_pc, prev_instr, prev_addr, e_instr;
    prev_hold = 1'b0;
    prev_wait = 1'b0;
    prev_pc = '0; prev_instr = '0; prev_addr = '0;
    exp_pc = RPC;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      imem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mdata(mq[0].addr);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
      end
      #3;
      if (rst) begin
        chk("rst_req", 64'(imem_req), 64'(0));
        chk("rst_valid", 64'(if_valid), 64'(0));
        mq.delete();
        exp_pc = RPC;
        prev_hold = 1'b0;
        prev_wait = 1'b0;
      end else begin
        if (imem_rvalid) void'(mq.pop_front());
        if (imem_req) chk("addr_align", 64'(imem_addr[1:0]), 64'(0));
        if (prev_wait && imem_req) chk("addr_hold", 64'(imem_addr), 64'(prev_addr));
        if (prev_hold) begin
          chk("hold_valid", 64'(if_valid), 64'(1));
          chk("hold_pc", 64'(if_pc), 64'(prev_pc));
          chk("hold_instr", 64'(if_instr), 64'(prev_instr));
        end
        if (if_valid && if_ready) begin
          e_instr = mdata(exp_pc);
          chk("deliver_pc", 64'(if_pc), 64'(exp_pc));
          chk("deliver_instr", 64'(if_instr), 64'(e_instr));
          chk("deliver_op", 64'(if_opcode), 64'(e_instr[6:0]));
          dlog.push_back(if_pc);
          dcyc.push_back(cyc);
          exp_pc = exp_pc + 32'd4;
        end
        if (imem_req && imem_gnt) mq.push_back('{imem_addr, cyc + lat});
        chk("inflight_cap", 64'(mq.size() <= DEPTH), 64'(1));
`ifdef IFU_MISALIGN_CHECK_EN
        if (redirect) exp_pc = redirect_pc;
`else
        if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
`endif
        prev_hold  = if_valid && !if_ready && !redirect;
        prev_pc    = if_pc;
        prev_instr = if_instr;
        prev_wait  = imem_req && !imem_gnt && !redirect;
        prev_addr  = imem_addr;
      end
    end
  end

  task automatic do_redirect(input logic [31:0] target);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = target;
    @(negedge clk);
    redirect = 1'b0;
    dlog.delete();
    dcyc.delete();
  endtask

  initial begin : stim
    bit found;
    rst = 1'b1; if_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (3) @(negedge clk);
    #4;
    chk("reset_req", 64'(imem_req), 64'(0));
    chk("reset_addr", 64'(imem_addr), 64'(RPC));
    chk("reset_valid", 64'(if_valid), 64'(0));
    chk("reset_instr", 64'(if_instr), 64'h13);
    chk("reset_pc", 64'(if_pc), 64'(RPC));

    // Zero-wait streaming
    @(negedge clk);
    rst = 1'b0; if_ready = 1'b1;
    dlog.delete(); dcyc.delete();
    @(negedge clk);
    #4;
    chk("first_req", 64'(imem_req), 64'(1));
    chk("first_addr", 64'(imem_addr), 64'(RPC));
    wait_dlog(10, 100);
    for (int i = 0; i < 6; i++) chk("seq_pc", 64'(dlog[i]), 64'(RPC + 32'(4 * i)));
    for (int i = 0; i < 8; i++) chk("gapless", 64'(dcyc[i+1] - dcyc[i]), 64'(1));

    // 3-cycle latency with decode stalled for 10 cycles
    lat = 3;
    dlog.delete();
    wait_dlog(3, 100);
    @(negedge clk);
    if_ready = 1'b0;
    repeat (10) @(negedge clk);
    #4;
    chk("stall_req", 64'(imem_req), 64'(0));
    chk("stall_valid", 64'(if_valid), 64'(1));
    chk("stall_inflight", 64'(mq.size()), 64'(0));
    @(negedge clk);
    if_ready = 1'b1;
    dlog.delete();
    repeat (4) @(negedge clk);
    chk("stall_buffered", 64'(dlog.size()), 64'(DEPTH));

    // Random wait states
    gnt_rand = 1'b1; lat = 2;
    repeat (40) @(negedge clk);
    gnt_rand = 1'b0;

    // Redirect with two requests in flight
    lat = 3;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (mq.size() == 2) found = 1'b1;
    end
    chk("two_inflight", 64'(mq.size()), 64'(2));
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    dlog.delete();
    wait_dlog(2, 100);
    chk("redir_first", 64'(dlog[0]), 64'h100);
    chk("redir_second", 64'(dlog[1]), 64'h104);

    // Redirect coinciding with a response and a pop
    lat = 1;
    dlog.delete();
    wait_dlog(4, 100);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h40;
    #4;
    chk("coinc_pop", 64'(if_valid && if_ready), 64'(1));
    chk("coinc_rvalid", 64'(imem_rvalid), 64'(1));
    @(negedge clk);
    redirect = 1'b0;
    dlog.delete();
    #4;
    chk("coinc_flush", 64'(if_valid), 64'(0));
    wait_dlog(2, 100);
    chk("coinc_first", 64'(dlog[0]), 64'h40);
    chk("coinc_second", 64'(dlog[1]), 64'h44);

    // PC wrap-around
    do_redirect(32'hFFFF_FFF8);
    wait_dlog(3, 100);
    chk("wrap_0", 64'(dlog[0]), 64'hFFFF_FFF8);
    chk("wrap_1", 64'(dlog[1]), 64'hFFFF_FFFC);
    chk("wrap_2", 64'(dlog[2]), 64'h0);

    // Reset mid-stream
    @(negedge clk);
    rst = 1'b1;
    #4;
    chk("midrst_valid", 64'(if_valid), 64'(0));
    chk("midrst_req", 64'(imem_req), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dlog.delete();
    wait_dlog(2, 50);
    chk("refetch_0", 64'(dlog[0]), 64'(RPC));
    chk("refetch_1", 64'(dlog[1]), 64'(RPC + 32'd4));

`ifdef IFU_MISALIGN_CHECK_EN
    do_redirect(32'h102);
    #4;
    chk("misalign_flag", 64'(fetch_misaligned), 64'(1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #4;
      chk("misalign_noreq", 64'(imem_req), 64'(0));
    end
    chk("misalign_nodeliver", 64'(dlog.size()), 64'(0));
    do_redirect(32'h200);
    #4;
    chk("misalign_clear", 64'(fetch_misaligned), 64'(0));
    wait_dlog(2, 100);
    chk("resume_0", 64'(dlog[0]), 64'h200);
    chk("resume_1", 64'(dlog[1]), 64'h204);
`else
    do_redirect(32'h102);
    wait_dlog(2, 100);
    chk("forced_align_0", 64'(dlog[0]), 64'h100);
    chk("forced_align_1", 64'(dlog[1]), 64'h104);
`endif

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit feeding the decode stage and the opcode-driven control decoder. Generates sequential PCs and issues word requests to instruction memory, which may insert wait states and keep several requests in flight. Buffers returned instructions and presents them to decode over a valid/ready handshake. Discards wrong-path instructions on a taken-branch redirect.

## Interface
Parameters:
- XLEN, 32, address/PC width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- BUF_DEPTH, 2, instruction buffer entries; also the cap on requests in flight; power of 2, ≥2

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  request valid
- imem_addr  out  XLEN  word address of the request; [1:0] always 2'b00
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response data valid; in order, ≥1 cycle after its grant
- imem_rdata  in  32  response instruction
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts the instruction
- if_instr  out  32  instruction word
- if_pc  out  XLEN  PC of if_instr
- if_opcode  out  7  if_instr[6:0], drives the control decoder Opcode input
- redirect  in  1  taken branch, one-cycle pulse
- redirect_pc  in  XLEN  branch target

## Operation
- State: fetch_pc, outstanding count (0..BUF_DEPTH), drop count (0..BUF_DEPTH), buffer of {pc, instr}.
- Issue: imem_req=1 when outstanding + occupancy < BUF_DEPTH. Hold imem_addr=fetch_pc until imem_gnt. On grant: fetch_pc += 4, outstanding++. fetch_pc wraps modulo 2^XLEN.
- Response: on imem_rvalid, outstanding--. If drop>0, drop-- and discard the data. Otherwise push {pc, rdata}. The response pc is tracked by a PC queue or a response-PC register. Overflow cannot occur by construction.
- Pop: on if_valid && if_ready.
- Redirect in cycle t:
  - Flush the buffer, including an entry popped in t, which counts as consumed.
  - drop := outstanding after t's grant/response updates, excluding any response discarded in t.
  - fetch_pc := redirect_pc. Any grant in t is counted in drop.
  - imem_req may assert in t+1 with imem_addr = redirect_pc.
- Redirect has priority over push.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=RESET_PC, counts 0.
- First imem_req=1 occurs in the first clock after rst deasserts.
- Latency: rvalid at t gives if_valid at t+1. There is no combinational bypass.
- Zero-wait memory (gnt in the same cycle, rvalid next) with if_ready held high sustains one instruction per cycle only when BUF_DEPTH ≥ 2.
- if_instr/if_pc stay stable while if_valid && !if_ready.
- imem_addr stays stable while imem_req && !imem_gnt. A redirect may change it the next cycle; memory treats the ungranted request as withdrawn.
- rst asserted mid-operation: all state clears immediately. Late responses after reset are the memory's responsibility; the block treats them as ordinary responses.

## Configuration
- IFU_MISALIGN_CHECK_EN
  - Defined: a redirect_pc with [1:0]≠0 sets sticky output fetch_misaligned (1 bit, reset 0). Issue stops, and in-flight responses are dropped. The next aligned redirect clears the flag and resumes fetch.
  - Undefined: the port is absent, and redirect_pc[1:0] is forced to 2'b00.

## Structure
- Package ifu_pkg holds:
  - XLEN default and the NOP constant 32'h0000_0013.
  - Opcode constants shared with the control decoder: OP_RTYPE 7'b0110011, OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_BRANCH 7'b1100011.
  - The {pc, instr} entry typedef.
- Sub-module ifu_fifo: synchronous FIFO with flush, depth BUF_DEPTH, width XLEN+32, count output.

## Test plan
- Zero-wait memory returning addr-tagged data, if_ready=1 -> if_pc 0,4,8,12… on consecutive cycles, if_opcode = rdata[6:0], no gaps after warm-up.
- Memory with 3-cycle response latency, if_ready=0 for 10 cycles -> exactly BUF_DEPTH entries buffered, imem_req=0, no data lost, order preserved on release.
- redirect to 0x100 while 2 requests are in flight -> both responses dropped; first delivered if_pc=0x100, followed by 0x104.
- redirect in the same cycle as imem_rvalid and if_valid&&if_ready -> popped instruction consumed once, rvalid data dropped, if_valid=0 the next cycle.
- fetch_pc at 0xFFFF_FFFC -> next request address 0x0000_0000.
- rst pulse mid-stream -> if_valid=0 and imem_req=0 during reset; refetch from RESET_PC afterwards. With IFU_MISALIGN_CHECK_EN, redirect_pc=0x102 -> fetch_misaligned=1 and no requests; redirect to 0x200 -> flag clears and fetch resumes.
